// File: rtl/acumulador_pkg.sv
// Shared types and constants for the nibble accumulator entry stage.
package acumulador_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, PUSH} acum_state_t;
  localparam int NIB_W = 4;
endpackage

// File: rtl/acumulador_nibbles.sv
// Builds an N-bit word from nibbles (first nibble most significant) and emits
// a one-cycle push carrying the word to the downstream holding register.
module acumulador_nibbles
  import acumulador_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              nib_valid_i,
  input  logic [NIB_W-1:0]                  nib_i,
  output logic                              nib_ready_o,
  input  logic                              commit_i,
  input  logic                              clear_i,
  output logic                              push_o,
  output logic [N-1:0]                      data_o,
  output logic [$clog2((N/NIB_W)+1)-1:0]    count_o,
  output logic                              full_o
);
  localparam int NIBBLES = N / NIB_W;
  localparam int CW      = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] NIB_MAX = CW'(NIBBLES);

  if ((N % NIB_W) != 0 || N < NIB_W) begin : g_bad_n
    $error("acumulador_nibbles: N must be a multiple of 4 and >= 4");
  end

  acum_state_t   state_q, state_d;
  logic [N-1:0]  acc_q, acc_d, acc_nx;
  logic [CW-1:0] count_q, count_d, cnt_nx;
  logic [N-1:0]  data_d;
  logic          push_d;
  logic          accept;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    push_d      = 1'b0;
    data_d      = data_o;
    nib_ready_o = (state_q != PUSH) && (count_q < NIB_MAX);
    accept      = nib_valid_i && nib_ready_o;
    // shift form stays legal for N == 4 where a part-select would go negative
    acc_nx      = accept ? ((acc_q << NIB_W) | N'(nib_i)) : acc_q;
    cnt_nx      = count_q + CW'(accept);

    if (state_q == PUSH) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
    end else if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
    end else if (commit_i && (cnt_nx != '0)) begin
      // a nibble accepted alongside the commit is part of the pushed word
      state_d = PUSH;
      acc_d   = acc_nx;
      count_d = cnt_nx;
      push_d  = 1'b1;
      data_d  = acc_nx;
    end else if (accept) begin
      state_d = ACCUM;
      acc_d   = acc_nx;
      count_d = cnt_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      push_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      push_o  <= push_d;
      data_o  <= data_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == NIB_MAX);
endmodule

// File: tb/tb_acumulador_nibbles.sv
// Drives N=16 and N=32 instances with shared stimulus; each is checked against
// a word/nibble-count model derived from the entry rules.
module tb_acumulador_nibbles;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, nib_valid_i, commit_i, clear_i;
  logic [3:0] nib_i;

  logic        r16, p16, f16, r32, p32, f32;
  logic [15:0] d16;
  logic [31:0] d32;
  logic [2:0]  c16;
  logic [3:0]  c32;

  acumulador_nibbles #(.N(16)) u16 (
    .clk_i(clk_i), .rst_i(rst_i), .nib_valid_i(nib_valid_i), .nib_i(nib_i),
    .nib_ready_o(r16), .commit_i(commit_i), .clear_i(clear_i),
    .push_o(p16), .data_o(d16), .count_o(c16), .full_o(f16));

  acumulador_nibbles #(.N(32)) u32 (
    .clk_i(clk_i), .rst_i(rst_i), .nib_valid_i(nib_valid_i), .nib_i(nib_i),
    .nib_ready_o(r32), .commit_i(commit_i), .clear_i(clear_i),
    .push_o(p32), .data_o(d32), .count_o(c32), .full_o(f32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // model: the word is plain base-16 arithmetic over accepted nibbles
  int          cap[2] = '{4, 8};
  int          m_cnt[2];
  logic [31:0] m_word[2], m_data[2];
  bit          m_push[2], m_inpush[2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit          rdy, acc;
      int          nc;
      logic [31:0] nw;
      if (rst_i) begin
        m_cnt[k] = 0; m_word[k] = 0; m_data[k] = 0; m_push[k] = 0; m_inpush[k] = 0;
      end else if (m_inpush[k]) begin
        m_inpush[k] = 0; m_push[k] = 0; m_cnt[k] = 0; m_word[k] = 0;
      end else begin
        rdy = (m_cnt[k] < cap[k]);
        acc = nib_valid_i && rdy;
        nw  = acc ? (m_word[k] * 16 + 32'(nib_i)) : m_word[k];
        nc  = m_cnt[k] + (acc ? 1 : 0);
        m_push[k] = 0;
        if (clear_i) begin
          m_cnt[k] = 0; m_word[k] = 0;
        end else if (commit_i && nc > 0) begin
          m_push[k] = 1; m_inpush[k] = 1; m_data[k] = nw; m_cnt[k] = nc; m_word[k] = nw;
        end else begin
          m_cnt[k] = nc; m_word[k] = nw;
        end
      end
    end
  endtask

  task automatic compare();
    chk("push16", 32'(p16), 32'(m_push[0]));
    chk("data16", 32'(d16), m_data[0]);
    chk("rdy16",  32'(r16), 32'(!m_inpush[0] && m_cnt[0] < cap[0]));
    chk("push32", 32'(p32), 32'(m_push[1]));
    chk("data32", d32, m_data[1]);
    chk("rdy32",  32'(r32), 32'(!m_inpush[1] && m_cnt[1] < cap[1]));
    if (!m_inpush[0]) begin
      chk("cnt16",  32'(c16), 32'(m_cnt[0]));
      chk("full16", 32'(f16), 32'(m_cnt[0] == cap[0]));
    end
    if (!m_inpush[1]) begin
      chk("cnt32",  32'(c32), 32'(m_cnt[1]));
      chk("full32", 32'(f32), 32'(m_cnt[1] == cap[1]));
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_in();
    rst_i = 0; nib_valid_i = 0; nib_i = 0; commit_i = 0; clear_i = 0;
  endtask

  task automatic nib(input logic [3:0] v);
    nib_valid_i = 1; nib_i = v; cyc(); nib_valid_i = 0;
  endtask

  task automatic commit();
    commit_i = 1; cyc(); commit_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; cyc(); rst_i = 0;
  endtask

  initial begin
    idle_in();
    do_reset();
    chk("rst_push", 32'(p16), 0);
    chk("rst_data", 32'(d16), 0);
    chk("rst_cnt",  32'(c16), 0);
    chk("rst_rdy",  32'(r16), 1);

    // entry and commit
    nib(4'hA); nib(4'hB); nib(4'hC);
    commit();
    chk("s1_push16", 32'(p16), 1);
    chk("s1_data16", 32'(d16), 32'h0ABC);
    chk("s1_data32", d32, 32'h00000ABC);
    cyc();
    chk("s1_push_off", 32'(p16), 0);
    chk("s1_cnt0", 32'(c16), 0);
    chk("s1_hold", 32'(d16), 32'h0ABC);

    // full, fifth nibble held off
    do_reset();
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    chk("full_f", 32'(f16), 1);
    chk("full_rdy", 32'(r16), 0);
    nib_valid_i = 1; nib_i = 4'h5; cyc(); cyc(); nib_valid_i = 0;
    chk("full_cnt", 32'(c16), 4);
    commit();
    chk("full_data", 32'(d16), 32'h1234);
    cyc();

    // nibble together with commit
    nib(4'h1); nib(4'h2);
    nib_valid_i = 1; nib_i = 4'hF; commit_i = 1; cyc(); nib_valid_i = 0; commit_i = 0;
    chk("nc_push", 32'(p16), 1);
    chk("nc_data", 32'(d16), 32'h012F);
    cyc();
    chk("nc_single", 32'(p16), 0);

    // clear, then empty commit
    nib(4'h7); nib(4'h8);
    clear_i = 1; cyc(); clear_i = 0;
    chk("clr_cnt", 32'(c16), 0);
    chk("clr_push", 32'(p16), 0);
    commit();
    chk("empty_push", 32'(p16), 0);
    chk("empty_data", 32'(d16), 32'h012F);

    // clear wins over commit
    nib(4'h3);
    clear_i = 1; commit_i = 1; cyc(); clear_i = 0; commit_i = 0;
    chk("cc_push", 32'(p16), 0);
    chk("cc_cnt", 32'(c16), 0);

    // reset during the push cycle
    nib(4'h9);
    commit();
    rst_i = 1; cyc(); rst_i = 0;
    chk("rp_push", 32'(p16), 0);
    chk("rp_data", 32'(d16), 0);
    chk("rp_rdy",  32'(r16), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i       = ($urandom_range(0, 99) < 2);
      nib_valid_i = ($urandom_range(0, 99) < 60);
      nib_i       = 4'($urandom);
      commit_i    = ($urandom_range(0, 99) < 15);
      clear_i     = ($urandom_range(0, 99) < 5);
      cyc();
    end
    idle_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
